// File: rtl/sine_table_arbiter.sv
// Round-robin arbiter sharing one sine_table lookup port among NUM_REQ requesters.
// Optional per-requester grant counters when SINE_ARB_STATS_EN is defined.
module sine_table_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [NUM_REQ-1:0]          req_valid_in,
  input  logic [NUM_REQ*ID_WIDTH-1:0] req_id_in,
  output logic [NUM_REQ-1:0]          req_ready_out,
  output logic [ID_WIDTH-1:0]         table_id_out,
  input  logic [DATA_WIDTH-1:0]       table_data_in,
  output logic [NUM_REQ-1:0]          resp_valid_out,
  output logic [DATA_WIDTH-1:0]       resp_data_out,
  output logic                        busy_out
`ifdef SINE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]       grant_count_out
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic [NUM_REQ-1:0] tag_q [LATENCY+1];
  logic [DATA_WIDTH-1:0] resp_hold_q;

  // Handshake: requester i transfers in a cycle where req_valid_in[i] and
  // req_ready_out[i] are both high; ready never rises without valid, and
  // responses have no back-pressure.
  always_comb begin
    int idx;
    idx           = 0;
    req_ready_out = '0;
    grant_idx     = '0;
    grant_any     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant_any && req_valid_in[idx]) begin
        grant_any          = 1'b1;
        grant_idx          = PTR_W'(idx);
        req_ready_out[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ptr_q        <= '0;
      table_id_out <= '0;
    end else if (grant_any) begin
      table_id_out <= req_id_in[int'(grant_idx)*ID_WIDTH +: ID_WIDTH];
      if (grant_idx == PTR_W'(NUM_REQ-1))
        ptr_q <= '0;
      else
        ptr_q <= grant_idx + PTR_W'(1);
    end
  end

  // One-hot grant travels alongside the lookup so the returning sample finds its owner.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int s = 0; s <= LATENCY; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= req_ready_out;
      for (int s = 1; s <= LATENCY; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      resp_hold_q <= '0;
    else if (|resp_valid_out)
      resp_hold_q <= table_data_in;
  end

  assign resp_valid_out = tag_q[LATENCY];
  // The table sample lands in the same cycle its tag reaches the last stage.
  assign resp_data_out  = (|resp_valid_out) ? table_data_in : resp_hold_q;

  always_comb begin
    busy_out = 1'b0;
    for (int s = 0; s <= LATENCY; s++) busy_out = busy_out | (|tag_q[s]);
  end

`ifdef SINE_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (grant_any) begin
      cnt_q[grant_idx] <= cnt_q[grant_idx] + 16'd1;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    assign grant_count_out[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_sine_table_arbiter.sv
// Self-checking bench for sine_table_arbiter with a registered 2-stage sine table model.
// Define SINE_ARB_STATS_EN to also exercise the grant counters.
module tb_sine_table_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int ID_WIDTH   = 12;
  localparam int DATA_WIDTH = 32;
  localparam int LATENCY    = 2;
  localparam int W          = 32 + NUM_REQ + DATA_WIDTH;

  logic                        clk_in = 1'b0;
  logic                        rst_in = 1'b1;
  logic [NUM_REQ-1:0]          req_valid_in = '0;
  logic [NUM_REQ*ID_WIDTH-1:0] req_id_in = '0;
  logic [NUM_REQ-1:0]          req_ready_out;
  logic [ID_WIDTH-1:0]         table_id_out;
  logic [DATA_WIDTH-1:0]       table_data_in;
  logic [NUM_REQ-1:0]          resp_valid_out;
  logic [DATA_WIDTH-1:0]       resp_data_out;
  logic                        busy_out;
`ifdef SINE_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]       grant_count_out;
`endif

  sine_table_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LATENCY(LATENCY)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .req_valid_in(req_valid_in),
    .req_id_in(req_id_in),
    .req_ready_out(req_ready_out),
    .table_id_out(table_id_out),
    .table_data_in(table_data_in),
    .resp_valid_out(resp_valid_out),
    .resp_data_out(resp_data_out),
    .busy_out(busy_out)
`ifdef SINE_ARB_STATS_EN
    ,
    .grant_count_out(grant_count_out)
`endif
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  // Sine table model: LATENCY registered stages from id to data.
  function automatic logic [DATA_WIDTH-1:0] sine_f(input logic [ID_WIDTH-1:0] id);
    real r;
    r = $sin(6.283185307179586 * real'(id) / 4096.0) * 1073741823.0;
    return DATA_WIDTH'($rtoi(r));
  endfunction

  logic [DATA_WIDTH-1:0] tbl_s [LATENCY];
  always @(posedge clk_in) begin
    tbl_s[0] <= sine_f(table_id_out);
    for (int s = 1; s < LATENCY; s++) tbl_s[s] <= tbl_s[s-1];
  end
  assign table_data_in = tbl_s[LATENCY-1];

  // Scoreboard state
  logic [W-1:0]          exp_q[$];
  int                    n_cmp = 0;
  int                    n_bad = 0;
  int                    cyc = 0;
  int                    ptr_m = 0;
  logic [DATA_WIDTH-1:0] last_data_m = '0;
  logic [15:0]           cnt_m [NUM_REQ];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    logic         exp_busy;
    exp_busy = 1'b0;
    foreach (exp_q[i])
      if (int'(exp_q[i][W-1 -: 32]) <= cyc + LATENCY) exp_busy = 1'b1;
    check("busy", 64'(busy_out), 64'(exp_busy));
    if (exp_q.size() > 0 && int'(exp_q[0][W-1 -: 32]) == cyc) begin
      e = exp_q.pop_front();
      check("resp_valid", 64'(resp_valid_out), 64'(e[DATA_WIDTH +: NUM_REQ]));
      check("resp_data", 64'(resp_data_out), 64'(e[DATA_WIDTH-1:0]));
      last_data_m = e[DATA_WIDTH-1:0];
    end else begin
      check("resp_idle", 64'(resp_valid_out), 64'(0));
      check("resp_hold", 64'(resp_data_out), 64'(last_data_m));
    end
  endtask

  // Driver: one cycle of stimulus, sampled 1 time unit after the falling edge.
  task automatic step(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*ID_WIDTH-1:0] ids);
    logic [NUM_REQ-1:0] exp_g;
    int g;
    @(negedge clk_in);
    cyc++;
    req_valid_in = v;
    req_id_in    = ids;
    #1;
    check_outputs();
    exp_g = '0;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (ptr_m + k) % NUM_REQ;
      if (g < 0 && v[idx]) g = idx;
    end
    if (g >= 0) exp_g[g] = 1'b1;
    check("ready", 64'(req_ready_out), 64'(exp_g));
    if (g >= 0 && !rst_in) begin
      exp_q.push_back({32'(cyc + 1 + LATENCY), exp_g, sine_f(ids[g*ID_WIDTH +: ID_WIDTH])});
      ptr_m = (g + 1) % NUM_REQ;
      cnt_m[g] = cnt_m[g] + 16'd1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0);
  endtask

  function automatic logic [NUM_REQ*ID_WIDTH-1:0] rand_ids();
    logic [NUM_REQ*ID_WIDTH-1:0] r;
    for (int i = 0; i < NUM_REQ; i++) r[i*ID_WIDTH +: ID_WIDTH] = ID_WIDTH'($urandom_range(0, 4095));
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    ptr_m = 0;
    last_data_m = '0;
    for (int i = 0; i < NUM_REQ; i++) cnt_m[i] = '0;
  endtask

  initial begin
    logic [NUM_REQ*ID_WIDTH-1:0] ids;
    model_reset();

    // Reset held, then released with no requests
    idle(3);
    rst_in = 1'b0;
    check("reset_table_id", 64'(table_id_out), 64'(0));
    idle(10);

    // Single requester 2 looks up 0x400
    ids = '0;
    ids[2*ID_WIDTH +: ID_WIDTH] = 12'h400;
    step(4'b0100, ids);
    idle(4);

    // All four requesters valid continuously
    for (int i = 0; i < 12; i++) step(4'b1111, rand_ids());
    idle(4);

    // Bring pointer to 2, then requesters 1 and 3 contend
    step(4'b0010, rand_ids());
    step(4'b1010, rand_ids());
    step(4'b0010, rand_ids());
    step(4'b1111, rand_ids());
    idle(4);

    // Reset with three lookups in flight
    for (int i = 0; i < 4; i++) step(4'b1111, rand_ids());
    #2;
    rst_in = 1'b1;
    #1;
    model_reset();
    check("rst_table_id", 64'(table_id_out), 64'(0));
    check("rst_resp_valid", 64'(resp_valid_out), 64'(0));
    check("rst_resp_data", 64'(resp_data_out), 64'(0));
    check("rst_busy", 64'(busy_out), 64'(0));
    idle(2);
    rst_in = 1'b0;
    idle(6);
    step(4'b1111, rand_ids());
    idle(4);

    // Random traffic
    for (int i = 0; i < 60; i++) step(NUM_REQ'($urandom_range(0, 15)), rand_ids());
    idle(5);
    check("drain", 64'(exp_q.size()), 64'(0));

`ifdef SINE_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++)
      check("grant_count", 64'(grant_count_out[i*16 +: 16]), 64'(cnt_m[i]));
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    model_reset();
    check("cnt_reset", 64'(grant_count_out), 64'(0));
    rst_in = 1'b0;
    for (int i = 0; i < 65537; i++) step(4'b0001, rand_ids());
    idle(5);
    check("cnt_wrap", 64'(grant_count_out[15:0]), 64'(16'd1));
    check("cnt_wrap_model", 64'(grant_count_out[15:0]), 64'(cnt_m[0]));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
